// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rasterises one filled (or optionally outlined) rectangle per
// request into a pixel-write stream for vga_adapter, one pixel per clock.
// Optional feature macro: RECT_FILL_OUTLINE_EN (adds iOutline, border-only plotting).
// Ports:
//   iClock, iReset       clock, asynchronous active-high reset
//   iValid / oReady      request handshake; accepted when both high at a rising edge
//   iX0, iY0, iW, iH     rectangle origin and size (W or H of 0 = empty)
//   iColour              fill colour
//   oX, oY, oColour      pixel position/colour (valid only when oPlot=1)
//   oPlot                pixel write strobe
//   oBusy                high while sweeping or completing
//   oDone                one-cycle completion pulse
//   iOutline             border-only mode (RECT_FILL_OUTLINE_EN builds only)
module rect_fill_engine #(
  parameter int unsigned X_BITS      = 9,
  parameter int unsigned Y_BITS      = 8,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned COLOUR_BITS = 3
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [X_BITS-1:0]      iX0,
  input  logic [Y_BITS-1:0]      iY0,
  input  logic [X_BITS-1:0]      iW,
  input  logic [Y_BITS-1:0]      iH,
  input  logic [COLOUR_BITS-1:0] iColour,
  output logic [X_BITS-1:0]      oX,
  output logic [Y_BITS-1:0]      oY,
  output logic [COLOUR_BITS-1:0] oColour,
  output logic                   oPlot,
  output logic                   oBusy,
  output logic                   oDone
`ifdef RECT_FILL_OUTLINE_EN
  ,
  input  logic                   iOutline
`endif
);

  localparam int unsigned XW1 = X_BITS + 1;
  localparam int unsigned YW1 = Y_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [X_BITS-1:0]      x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [Y_BITS-1:0]      y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic [COLOUR_BITS-1:0] col_q, col_d;
  logic                   outline_q, outline_d;
  logic [X_BITS-1:0]      x_q, x_d;
  logic [Y_BITS-1:0]      y_q, y_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic                   plot_q, plot_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   outline_in;

`ifdef RECT_FILL_OUTLINE_EN
  assign outline_in = iOutline;
`else
  assign outline_in = 1'b0;
`endif

  // Plot decision for pixel (cx,cy): on-screen test at widened precision, plus border mask.
  function automatic logic pix_on(input logic [X_BITS-1:0] x0, input logic [X_BITS-1:0] cx,
                                  input logic [X_BITS-1:0] w,  input logic [Y_BITS-1:0] y0,
                                  input logic [Y_BITS-1:0] cy, input logic [Y_BITS-1:0] h,
                                  input logic outline);
    logic [XW1-1:0] px;
    logic [YW1-1:0] py;
    logic           border;
    px     = XW1'(x0) + XW1'(cx);
    py     = YW1'(y0) + YW1'(cy);
    border = (cx == X_BITS'(0)) || (cx == w - X_BITS'(1)) ||
             (cy == Y_BITS'(0)) || (cy == h - Y_BITS'(1));
    return (px < XW1'(SCREEN_W)) && (py < YW1'(SCREEN_H)) && (!outline || border);
  endfunction

  // Next-state and registered-output computation; outputs describe the pixel shown next cycle.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    outline_d = outline_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          x0_d      = iX0;
          y0_d      = iY0;
          w_d       = iW;
          h_d       = iH;
          col_d     = iColour;
          outline_d = outline_in;
          cx_d      = X_BITS'(0);
          cy_d      = Y_BITS'(0);
          if ((iW == X_BITS'(0)) || (iH == Y_BITS'(0))) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_FILL;
            x_d      = iX0;
            y_d      = iY0;
            colour_d = iColour;
            plot_d   = pix_on(iX0, X_BITS'(0), iW, iY0, Y_BITS'(0), iH, outline_in);
          end
        end
      end
      S_FILL: begin
        if ((cx_q == w_q - X_BITS'(1)) && (cy_q == h_q - Y_BITS'(1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (cx_q == w_q - X_BITS'(1)) begin
            cx_d = X_BITS'(0);
            cy_d = cy_q + Y_BITS'(1);
          end else begin
            cx_d = cx_q + X_BITS'(1);
          end
          x_d      = x0_q + cx_d;
          y_d      = y0_q + cy_d;
          colour_d = col_q;
          plot_d   = pix_on(x0_q, cx_d, w_q, y0_q, cy_d, h_q, outline_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      outline_q <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      outline_q <= outline_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign oReady  = ready_q;
  assign oX      = x_q;
  assign oY      = y_q;
  assign oColour = colour_q;
  assign oPlot   = plot_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

endmodule
